// File: rtl/serial_deserializer.sv
// One-bit-per-clock serial receiver: start bit, DATA_W data bits LSB-first, optional even parity, stop bit.
// Define SERIAL_DESERIALIZER_PARITY_EN to add the parity bit between the data bits and the stop bit.
module serial_deserializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  output logic [DATA_W-1:0] byte_out,
  output logic              byte_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!din) state_nx = DATA;
      DATA: begin
        if (cnt == LAST_BIT) begin
`ifdef SERIAL_DESERIALIZER_PARITY_EN
          state_nx = PARITY;
`else
          state_nx = STOP;
`endif
        end
      end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
      PARITY:  state_nx = STOP;
`endif
      STOP:    state_nx = din ? IDLE : BREAK;
      // A line held low after a bad stop bit is a break, never a new start bit.
      BREAK:   if (din) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= (state_nx != IDLE);
      case (state)
        IDLE: if (!din) cnt <= '0;
        DATA: begin
          shreg <= {din, shreg[DATA_W-1:1]};
          cnt   <= cnt + CNT_W'(1);
        end
        STOP: begin
          if (din) begin
            byte_out   <= shreg;
            byte_valid <= 1'b1;
          end else begin
            frame_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_DESERIALIZER_PARITY_EN
  // Mismatch is captured at the parity bit and reported alongside the stop-bit outcome.
  logic par_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      if (state == PARITY) par_bad <= (^shreg) ^ din;
      if (state == STOP) parity_err <= par_bad;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer (DATA_W=8): table of frames plus hand-written reset/break/back-to-back sequences.
module tb_serial_deserializer;

`ifdef SERIAL_DESERIALIZER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       din;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int checks = 0;
  int failures = 0;

  serial_deserializer #(.DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         par_ok;
    bit         stop;
    logic [7:0] exp_out;
    bit         exp_valid;
    bit         exp_ferr;
    bit         exp_perr;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, 32'(byte_valid), 32'd0);
    check({tag, "_ferr"},  32'(frame_err),  32'd0);
    check({tag, "_perr"},  32'(parity_err), 32'd0);
  endtask

  // Drives start, data LSB-first, optional parity, stop; returns #1 after the stop edge.
  task automatic send_frame(input logic [7:0] data, input bit par_ok, input bit stop);
    din = 1'b0;
    tick();
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      din = data[i];
      tick();
    end
    if (PAR_EN) begin
      din = par_ok ? (^data) : ~(^data);
      tick();
    end
    check("valid_before_stop", 32'(byte_valid), 32'd0);
    din = stop;
    tick();
  endtask

  initial begin
    vecs[0] = '{8'h4A, 1'b1, 1'b1, 8'h4A, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h81, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, PAR_EN};
    vecs[5] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};

    // Reset held three cycles with din toggling
    reset = 1'b1;
    din   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = ~din;
      tick();
      check("rst_byte_out", 32'(byte_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check_quiet("rst");
    end
    reset = 1'b0;
    din   = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Table-driven frames
    for (int k = 0; k < 6; k++) begin
      send_frame(vecs[k].data, vecs[k].par_ok, vecs[k].stop);
      check($sformatf("v%0d_byte_out", k), 32'(byte_out),   32'(vecs[k].exp_out));
      check($sformatf("v%0d_valid", k),    32'(byte_valid), 32'(vecs[k].exp_valid));
      check($sformatf("v%0d_ferr", k),     32'(frame_err),  32'(vecs[k].exp_ferr));
      check($sformatf("v%0d_perr", k),     32'(parity_err), 32'(vecs[k].exp_perr));
      din = 1'b1;
      tick();
      check_quiet($sformatf("v%0d_post", k));
      check($sformatf("v%0d_busy_end", k), 32'(busy), 32'd0);
    end

    // Back-to-back: A5 then 3C with the second start bit on the edge after the first stop
    send_frame(8'hA5, 1'b1, 1'b1);
    check("b2b_first_valid", 32'(byte_valid), 32'd1);
    check("b2b_first_out",   32'(byte_out),   32'hA5);
    send_frame(8'h3C, 1'b1, 1'b1);
    check("b2b_second_valid", 32'(byte_valid), 32'd1);
    check("b2b_second_out",   32'(byte_out),   32'h3C);
    din = 1'b1;
    tick();
    check_quiet("b2b_post");

    // Bad stop, then three zeros held in break, then line returns high
    send_frame(8'h55, 1'b1, 1'b0);
    check("brk_ferr",  32'(frame_err),  32'd1);
    check("brk_valid", 32'(byte_valid), 32'd0);
    check("brk_out",   32'(byte_out),   32'h3C);
    for (int i = 0; i < 3; i++) begin
      din = 1'b0;
      tick();
      check("brk_hold_busy", 32'(busy), 32'd1);
      check_quiet("brk_hold");
    end
    din = 1'b1;
    tick();
    check("brk_exit_busy", 32'(busy), 32'd0);
    check_quiet("brk_exit");
    send_frame(8'h5A, 1'b1, 1'b1);
    check("brk_next_valid", 32'(byte_valid), 32'd1);
    check("brk_next_out",   32'(byte_out),   32'h5A);
    din = 1'b1;
    tick();

    // Reset during data bit 4, then a clean FF frame starting right after reset release
    din = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      din = 1'b1;
      tick();
    end
    reset = 1'b1;
    din   = 1'b0;
    tick();
    check("mid_rst_out",  32'(byte_out), 32'd0);
    check("mid_rst_busy", 32'(busy),     32'd0);
    check_quiet("mid_rst");
    reset = 1'b0;
    send_frame(8'hFF, 1'b1, 1'b1);
    check("post_rst_valid", 32'(byte_valid), 32'd1);
    check("post_rst_out",   32'(byte_out),   32'hFF);
    check("post_rst_ferr",  32'(frame_err),  32'd0);
    din = 1'b1;
    tick();
    check_quiet("post_rst_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
